// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index type and the pipeline controller state encoding.
package cpu_types_pkg;

  localparam int unsigned REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN,
    DWAIT,
    DCAP,
    HALT
  } pctrl_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detect: a load in EX writes a register that the instruction in ID reads.
module load_use_detect
  import cpu_types_pkg::*;
(
  input  logic     ex_MemRead,
  input  regbits_t ex_wsel,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  output logic     luhaz
);

  // $zero is never a real dependency.
  assign luhaz = ex_MemRead && (ex_wsel != '0) && ((ex_wsel == id_rs) || (ex_wsel == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: latch enables/flushes, pc_en, dcache gating, halt.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_redirect,
  input  logic             mem_halt,
  input  logic             ex_MemRead,
  input  regbits_t         ex_wsel,
  input  regbits_t         id_rs,
  input  regbits_t         id_rt,
  output logic             dREN,
  output logic             dWEN,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] dmiss_cycles
);

  pctrl_state_t state_q, state_d;
  logic         halted_q;
  logic         mop;
  logic         may_adv;
  logic         luhaz;

  assign mop    = mem_dREN | mem_dWEN;
  assign halted = halted_q;

  load_use_detect u_luse (
    .ex_MemRead (ex_MemRead),
    .ex_wsel    (ex_wsel),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .luhaz      (luhaz)
  );

  always_comb begin
    dREN        = 1'b0;
    dWEN        = 1'b0;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    may_adv     = 1'b0;
    state_d     = state_q;

    unique case (state_q)
      RUN: begin
        if (mop) begin
          dREN    = mem_dREN;
          dWEN    = mem_dWEN & ~mem_dREN;
          state_d = dhit ? DCAP : DWAIT;
        end else begin
          may_adv = 1'b1;
        end
      end
      DWAIT: begin
        dREN = mem_dREN;
        dWEN = mem_dWEN & ~mem_dREN;
        if (dhit) state_d = DCAP;
      end
      DCAP:    may_adv = 1'b1;
      HALT:    ;
      default: state_d = RUN;
    endcase

    // Without ihit nothing moves, so a pending halt/redirect simply waits in MEM.
    if (may_adv && ihit) begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      state_d  = RUN;
      if (mem_halt) begin
        pc_en       = 1'b0;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        state_d     = HALT;
      end else if (mem_redirect) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (luhaz) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end

    if (!nRST) begin
      dREN        = 1'b0;
      dWEN        = 1'b0;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
      state_d     = RUN;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_q | (state_d == HALT);
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] dmiss_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_q <= '0;
      dmiss_q <= '0;
    end else begin
      if ((state_q != HALT) && !pc_en && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
      if ((state_q == DWAIT) && !(&dmiss_q)) dmiss_q <= dmiss_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign dmiss_cycles = dmiss_q;
`else
  assign stall_cycles = '0;
  assign dmiss_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios then random traffic against a behavioural model.
module tb_pipeline_ctrl;

  localparam int unsigned CW  = 6;
  localparam int          SAT = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          ihit, dhit, mem_dREN, mem_dWEN, mem_redirect, mem_halt, ex_MemRead;
  logic [4:0]    ex_wsel, id_rs, id_rt;
  logic          dREN, dWEN, pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic          ifid_flush, idex_flush, exmem_flush, memwb_flush, halted;
  logic [CW-1:0] stall_cycles, dmiss_cycles;

  always #5 CLK = ~CLK;

  pipeline_ctrl #(.CNT_W(CW)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .ihit         (ihit),
    .dhit         (dhit),
    .mem_dREN     (mem_dREN),
    .mem_dWEN     (mem_dWEN),
    .mem_redirect (mem_redirect),
    .mem_halt     (mem_halt),
    .ex_MemRead   (ex_MemRead),
    .ex_wsel      (ex_wsel),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .dREN         (dREN),
    .dWEN         (dWEN),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_en      (idex_en),
    .exmem_en     (exmem_en),
    .memwb_en     (memwb_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .memwb_flush  (memwb_flush),
    .halted       (halted),
    .stall_cycles (stall_cycles),
    .dmiss_cycles (dmiss_cycles)
  );

  typedef struct packed {
    logic       rst_n, ih, dh, rd, wr, redir, hlt, exmr;
    logic [4:0] exw, rs, rt;
  } stim_t;

  typedef struct packed {
    int            cyc;
    logic [11:0]   flags;
    logic [CW-1:0] stall;
    logic [CW-1:0] dmiss;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  bit   skip   = 1'b1;

  // Model: the MEM instruction either needs its memory access, has had it, or is an ordinary one.
  bit m_halted = 1'b0;
  bit m_done   = 1'b0;
  int m_age    = 0;
  int m_stall  = 0;
  int m_dmiss  = 0;
  bit m_adv    = 1'b0;

  function automatic stim_t mk(input logic rst_n, ih, dh, rd, wr, redir, hlt, exmr,
                               input int exw, rs, rt);
    stim_t s;
    s = '{rst_n, ih, dh, rd, wr, redir, hlt, exmr, 5'(exw), 5'(rs), 5'(rt)};
    return s;
  endfunction

  task automatic step(input stim_t s);
    logic e_rd, e_wr, e_pc, e_ife, e_ide, e_eme, e_mwe, e_iff, e_idf, e_emf;
    bit   req, miss, hazard;
    exp_t e;
    @(posedge CLK);
    #1;
    nRST = s.rst_n; ihit = s.ih; dhit = s.dh; mem_dREN = s.rd; mem_dWEN = s.wr;
    mem_redirect = s.redir; mem_halt = s.hlt; ex_MemRead = s.exmr;
    ex_wsel = s.exw; id_rs = s.rs; id_rt = s.rt;
    assert (!(s.rd && s.wr)) else $error("illegal stimulus: load and store together");
    cyc++;
    {e_rd, e_wr, e_pc, e_ife, e_ide, e_eme, e_mwe, e_iff, e_idf, e_emf} = '0;
    req    = s.rst_n && !m_halted && (s.rd || s.wr) && !m_done;
    miss   = req && (m_age > 0);
    m_adv  = s.rst_n && !m_halted && !req && s.ih;
    hazard = s.exmr && (s.exw != 0) && ((s.exw == s.rs) || (s.exw == s.rt));
    if (req) begin
      e_rd = s.rd;
      e_wr = s.wr;
    end else if (m_adv) begin
      {e_pc, e_ife, e_ide, e_eme, e_mwe} = '1;
      if (s.hlt) begin
        e_pc = 1'b0;
        {e_iff, e_idf, e_emf} = '1;
      end else if (s.redir) begin
        {e_iff, e_idf, e_emf} = '1;
      end else if (hazard) begin
        e_pc  = 1'b0;
        e_ife = 1'b0;
        e_idf = 1'b1;
      end
    end
    e.cyc   = cyc;
    e.flags = {e_rd, e_wr, e_pc, e_ife, e_ide, e_eme, e_mwe, e_iff, e_idf, e_emf, 1'b0, m_halted};
`ifdef PIPE_CTRL_PERF_EN
    e.stall = CW'(m_stall);
    e.dmiss = CW'(m_dmiss);
`else
    e.stall = '0;
    e.dmiss = '0;
`endif
    if (!skip) q.push_back(e);
    skip = 1'b0;
    if (!s.rst_n) begin
      m_halted = 1'b0; m_done = 1'b0; m_age = 0; m_stall = 0; m_dmiss = 0;
    end else if (!m_halted) begin
      if (!e_pc && m_stall < SAT) m_stall++;
      if (miss && m_dmiss < SAT) m_dmiss++;
      if (req) begin
        if (s.dh) begin m_done = 1'b1; m_age = 0; end
        else m_age++;
      end else if (m_adv) begin
        m_done = 1'b0;
        if (s.hlt) m_halted = 1'b1;
      end
    end
  endtask

  always @(negedge CLK) begin
    exp_t        e;
    logic [11:0] got;
    if (q.size() > 0) begin
      e   = q.pop_front();
      got = {dREN, dWEN, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush, memwb_flush, halted};
      checks++;
      if (got !== e.flags) begin
        errors++;
        $display("FAIL flags cyc=%0d got=%b exp=%b (dREN dWEN pc ifid idex exmem memwb fl*4 halted)",
                 e.cyc, got, e.flags);
      end
      checks++;
      if ({stall_cycles, dmiss_cycles} !== {e.stall, e.dmiss}) begin
        errors++;
        $display("FAIL counters cyc=%0d got stall=%0d dmiss=%0d exp stall=%0d dmiss=%0d",
                 e.cyc, stall_cycles, dmiss_cycles, e.stall, e.dmiss);
      end
      checks++;
      if ((dREN & dWEN) !== 1'b0) begin
        errors++;
        $display("FAIL dren_dwen_excl cyc=%0d got dREN=%b dWEN=%b exp not both", e.cyc, dREN, dWEN);
      end
    end
  end

  stim_t cur;
  bit    need_new;
  int    halt_wait;

  initial begin
    nRST = 1'b0; ihit = 0; dhit = 0; mem_dREN = 0; mem_dWEN = 0; mem_redirect = 0;
    mem_halt = 0; ex_MemRead = 0; ex_wsel = 0; id_rs = 0; id_rt = 0;
    step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Free-running fetch.
    repeat (2) step(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2));
    // Load missing three cycles, then capture.
    repeat (3) step(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 2));
    step(mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 2));
    step(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 2));
    // Store hits immediately, icache misses twice in capture.
    step(mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 2));
    repeat (2) step(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 2));
    step(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 2));
    // Load-use on rt, then the same with $zero as destination.
    step(mk(1, 1, 0, 0, 0, 0, 0, 1, 8, 3, 8));
    step(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    // Redirect beats load-use.
    step(mk(1, 1, 0, 0, 0, 1, 0, 1, 8, 8, 4));
    // Halt, stay halted, then reset out of it.
    step(mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    repeat (2) step(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Long icache miss drives the stall counter into saturation.
    repeat (SAT + 8) step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    need_new  = 1'b1;
    halt_wait = 0;
    cur       = '0;
    for (int i = 0; i < 3000; i++) begin
      stim_t s;
      if (need_new) begin
        int k;
        k = $urandom_range(0, 99);
        cur.rd    = (k < 20);
        cur.wr    = (k >= 20) && (k < 35);
        cur.redir = (k >= 35) && (k < 45);
        cur.hlt   = (k == 45);
      end
      s       = cur;
      s.rst_n = 1'b1;
      s.ih    = ($urandom_range(0, 9) < 7);
      s.dh    = ($urandom_range(0, 9) < 4);
      s.exmr  = 1'($urandom_range(0, 1));
      s.exw   = 5'($urandom_range(0, 3));
      s.rs    = 5'($urandom_range(0, 3));
      s.rt    = 5'($urandom_range(0, 3));
      if (m_halted) begin
        halt_wait++;
        if (halt_wait > 3) begin
          s.rst_n   = 1'b0;
          halt_wait = 0;
        end
      end
      step(s);
      need_new = m_adv || !s.rst_n;
    end

    repeat (2) @(negedge CLK);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
